router_egress_merge: RTL

//   Downstream stage of the 1-to-4 address router. Captures the four routed

---
 rtl/router_egress_merge.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/router_egress_merge.sv
// Purpose : merge four routed lanes, each buffered in its own FIFO, onto one
//           valid/ready stream with round-robin arbitration and a source tag.
// Latency : word written at edge N is on dout after edge N+1 if it wins; 1 word/cycle.
// Backpressure: dout held while valid & ~ready; lanes show full and drop
//               writes when full (sticky overflow flag per lane).
//
// Ports:
//   clk, resetn             clock, async active-low reset
//   din0..din3, din_en      per-lane write data and strobes
//   full, overflow          per-lane FIFO full and sticky write-dropped flags
//   dout, dout_src          merged data and its source lane
//   dout_valid, dout_ready  output handshake

// Generic single-clock FIFO. Pushes into a full FIFO and pops from an empty
// one are ignored; full/empty come from the registered count only.
module router_egress_merge_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are unreachable while count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module router_egress_merge #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic [3:0]            din_en,
  output logic [3:0]            full,
  output logic [3:0]            overflow,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            dout_src,
  output logic                  dout_valid,
  input  logic                  dout_ready
);
  logic [DATA_WIDTH-1:0] lane_dat [4];
  logic [DATA_WIDTH-1:0] head_dat [4];
  logic [3:0]            empty;
  logic [3:0]            pop_vec;
  logic [1:0]            ptr;
  logic [1:0]            grant;
  logic                  grant_vld;
  logic                  load;

  assign lane_dat[0] = din0;
  assign lane_dat[1] = din1;
  assign lane_dat[2] = din2;
  assign lane_dat[3] = din3;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    router_egress_merge_fifo #(
      .W     (DATA_WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .push     (din_en[i]),
      .push_dat (lane_dat[i]),
      .pop      (pop_vec[i]),
      .head_dat (head_dat[i]),
      .empty    (empty[i]),
      .full     (full[i])
    );
  end

  // Output register has no skid buffer: it reloads whenever it is empty or
  // its current word is being taken this cycle.
  assign load = ~dout_valid | dout_ready;

  // Round-robin: search starts one past the last winner and wraps; the k=4
  // step revisits the last winner so a lone busy lane still streams.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!grant_vld && !empty[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  assign pop_vec = (load && grant_vld) ? (4'b0001 << grant) : 4'b0000;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout       <= '0;
      dout_src   <= '0;
      dout_valid <= 1'b0;
      ptr        <= 2'd3;
      overflow   <= '0;
    end else begin
      // full is the pre-edge value, so a write to a full lane is dropped
      // even when that lane pops in the same cycle.
      overflow <= overflow | (din_en & full);
      if (load) begin
        dout_valid <= grant_vld;
        if (grant_vld) begin
          dout     <= head_dat[grant];
          dout_src <= grant;
          ptr      <= grant;
        end
      end
    end
  end
endmodule
